// File: rtl/fp_acc.sv
// Streaming binary32 accumulator: running sum per accepted beat, tlast closes a group.
// Latency 1 cycle; single-cycle combinational adder so acc feeds back every cycle.
// Backpressure: a stalled result holds its output and drops s_axis_a_tready (no skid buffer).
module fp_acc (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axis_a_tdata,
  input  logic        s_axis_a_tvalid,
  input  logic        s_axis_a_tlast,
  output logic        s_axis_a_tready,
  output logic [31:0] m_axis_result_tdata,
  output logic        m_axis_result_tvalid,
  input  logic        m_axis_result_tready,
  output logic        m_axis_result_tlast
);

  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic [31:0] acc;
  logic        first;
  logic        accept;
  logic        a_is_nan;
  logic [31:0] sum;

  // Leading-zero count of the 27-bit working mantissa (27 when all zero).
  function automatic logic [4:0] clz27(input logic [26:0] v);
    logic [4:0] cnt;
    logic       found;
    cnt   = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        cnt   = 5'(26 - i);
        found = 1'b1;
      end
    end
    return cnt;
  endfunction

  // binary32 add, round-to-nearest-even, gradual underflow, canonical NaN.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic        a_nan, b_nan, a_inf, b_inf;
    logic        swap, sub, up;
    logic [31:0] x, y, res;
    logic [7:0]  ex, ey, d;
    logic [23:0] mx, my;
    logic [26:0] ax, ay_full, ay, n;
    logic [27:0] s;
    logic [9:0]  e, ef, lim, sh;
    logic [4:0]  lz;
    logic [24:0] r;
    logic [22:0] frac;

    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

    // x carries the larger magnitude; its sign wins for non-zero results.
    swap = b[30:0] > a[30:0];
    x    = swap ? b : a;
    y    = swap ? a : b;

    // Subnormals use exponent 1 with no hidden bit.
    ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx = {x[30:23] != 8'd0, x[22:0]};
    my = {y[30:23] != 8'd0, y[22:0]};
    d  = ex - ey;

    // Align the smaller operand with guard/round bits and a sticky LSB.
    ax      = {mx, 3'b000};
    ay_full = {my, 3'b000};
    if (d >= 8'd27) begin
      ay = {26'd0, |ay_full};
    end else begin
      ay    = ay_full >> d;
      ay[0] = ay[0] | (|(ay_full & ((27'd1 << d) - 27'd1)));
    end

    sub = x[31] ^ y[31];
    s   = sub ? ({1'b0, ax} - {1'b0, ay}) : ({1'b0, ax} + {1'b0, ay});
    e   = {2'b00, ex};

    // Normalize: carry-out shifts right, cancellation shifts left but never below exponent 1.
    lz  = clz27(s[26:0]);
    lim = e - 10'd1;
    sh  = ({5'd0, lz} < lim) ? {5'd0, lz} : lim;
    if (s[27]) begin
      n = {s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end else begin
      n = s[26:0] << sh;
      e = e - sh;
    end

    // Round to nearest even; mantissa carry bumps the exponent.
    up = n[2] & (n[1] | n[0] | n[3]);
    r  = {1'b0, n[26:3]} + {24'd0, up};
    if (r[24]) begin
      frac = r[23:1];
      ef   = e + 10'd1;
    end else begin
      frac = r[22:0];
      ef   = r[23] ? e : 10'd0;
    end

    if (a_nan || b_nan)        res = QNAN;
    else if (a_inf && b_inf)   res = (a[31] == b[31]) ? a : QNAN;
    else if (a_inf)            res = a;
    else if (b_inf)            res = b;
    else if (s == 28'd0)       res = {x[31] & y[31], 31'd0};
    else if (ef >= 10'd255)    res = {x[31], 8'hFF, 23'd0};
    else                       res = {x[31], ef[7:0], frac};
    return res;
  endfunction

  assign s_axis_a_tready = aresetn && (!m_axis_result_tvalid || m_axis_result_tready);
  assign accept          = s_axis_a_tvalid && s_axis_a_tready;
  assign a_is_nan        = (s_axis_a_tdata[30:23] == 8'hFF) && (s_axis_a_tdata[22:0] != 23'd0);

  // Next running sum: first beat of a group passes through (NaN canonicalized).
  always_comb begin
    sum = 32'd0;
    if (first) sum = a_is_nan ? QNAN : s_axis_a_tdata;
    else       sum = fp_add(acc, s_axis_a_tdata);
  end

  // Output register, accumulator and group-start flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc                  <= 32'd0;
      first                <= 1'b1;
      m_axis_result_tdata  <= 32'd0;
      m_axis_result_tlast  <= 1'b0;
      m_axis_result_tvalid <= 1'b0;
    end else if (accept) begin
      m_axis_result_tdata  <= sum;
      m_axis_result_tlast  <= s_axis_a_tlast;
      m_axis_result_tvalid <= 1'b1;
      if (s_axis_a_tlast) begin
        first <= 1'b1;
      end else begin
        first <= 1'b0;
        acc   <= sum;
      end
    end else if (m_axis_result_tready) begin
      m_axis_result_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_acc.sv
// Scoreboard bench for fp_acc: reference sums from exact fixed-point arithmetic.
// Driver pushes expected beats on acceptance; monitor pops on each output handshake.
// Random valid/ready patterns exercise backpressure and idle beats with junk data.
module tb_fp_acc;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_tdata = 32'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [32:0] exp_q[$];
  logic        m_first = 1'b1;
  logic [31:0] m_acc = 32'd0;
  logic        held = 1'b0;
  logic [31:0] held_d = 32'd0;
  logic        held_l = 1'b0;

  fp_acc dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_a_tdata       (s_tdata),
    .s_axis_a_tvalid      (s_tvalid),
    .s_axis_a_tlast       (s_tlast),
    .s_axis_a_tready      (s_tready),
    .m_axis_result_tdata  (m_tdata),
    .m_axis_result_tvalid (m_tvalid),
    .m_axis_result_tready (m_tready),
    .m_axis_result_tlast  (m_tlast)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Exact value in units of 2^-149 (the smallest subnormal).
  function automatic logic signed [300:0] to_fixed(input logic [31:0] x);
    logic signed [300:0] m;
    int e;
    e = int'(x[30:23]);
    m = '0;
    m[22:0] = x[22:0];
    if (e != 0) begin
      m[23] = 1'b1;
      m = m <<< (e - 1);
    end
    return x[31] ? -m : m;
  endfunction

  // Round an exact non-zero fixed-point value to binary32 (nearest even).
  function automatic logic [31:0] round_fixed(input logic signed [300:0] s);
    logic         sg;
    logic [300:0] mag, q, rem, half;
    int           p, sh, e;
    sg  = s[300];
    mag = sg ? 301'(-s) : 301'(s);
    p = 0;
    for (int i = 0; i < 301; i++) if (mag[i]) p = i;
    if (p < 23) return {sg, 8'd0, mag[22:0]};
    sh  = p - 23;
    q   = mag >> sh;
    rem = mag & ((301'd1 << sh) - 301'd1);
    if (sh > 0) begin
      half = 301'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 301'd1;
    end
    if (q[24]) begin
      q = q >> 1;
      p = p + 1;
    end
    e = p - 22;
    if (e >= 255) return {sg, 8'hFF, 23'd0};
    return {sg, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic a_inf, b_inf;
    logic signed [300:0] s;
    a_inf = (a[30:0] == 31'h7F800000);
    b_inf = (b[30:0] == 31'h7F800000);
    if (is_nan(a) || is_nan(b)) return 32'h7FC00000;
    if (a_inf && b_inf) return (a[31] == b[31]) ? a : 32'h7FC00000;
    if (a_inf) return a;
    if (b_inf) return b;
    s = to_fixed(a) + to_fixed(b);
    if (s == 0) return {a[31] & b[31], 31'd0};
    return round_fixed(s);
  endfunction

  function automatic logic [31:0] model_sum(input logic [31:0] a);
    if (m_first) return is_nan(a) ? 32'h7FC00000 : a;
    return ref_add(m_acc, a);
  endfunction

  // Record an accepted beat: expected result into the scoreboard, update model state.
  task automatic record(input logic [31:0] d, input logic l, input logic use_exp, input logic [31:0] e);
    logic [31:0] ex;
    ex = use_exp ? e : model_sum(d);
    exp_q.push_back({ex, l});
    if (l) m_first = 1'b1;
    else begin
      m_first = 1'b0;
      m_acc   = ex;
    end
  endtask

  // One clock of stimulus: drive after the falling edge, report whether the next rising edge accepts.
  task automatic cycle(input logic v, input logic [31:0] d, input logic l, input logic mr, output logic acc);
    @(negedge aclk);
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    m_tready = mr;
    #2;
    acc = v && s_tready;
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic use_exp, input logic [31:0] e);
    logic a;
    int   tries;
    tries = 0;
    a = 1'b0;
    while (!a && tries < 50) begin
      cycle(1'b1, d, l, 1'b1, a);
      tries++;
    end
    if (a) record(d, l, use_exp, e);
    else begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: beat %08h never accepted", d);
    end
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, 32'hDEADBEEF, 1'b1, 1'b1, a);
  endtask

  function automatic logic [31:0] gen_operand(input logic [31:0] acc);
    logic [31:0] sp [8];
    logic [31:0] r;
    logic        sg;
    sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
           32'h7FA00001, 32'h7F7FFFFF, 32'h00800000, 32'h807FFFFF};
    sg = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0, 1, 2: r = $urandom;
      3, 4, 5: r = {sg, 8'($urandom_range(118, 136)), 23'($urandom)};
      6:       r = {sg, 8'd0, 23'($urandom)};
      7:       r = {~acc[31], acc[30:0]} ^ {29'd0, 3'($urandom)};
      8:       r = sp[$urandom_range(0, 7)];
      default: r = {sg, 8'($urandom_range(250, 254)), 23'($urandom)};
    endcase
    return r;
  endfunction

  // Monitor: output valid must track the scoreboard, held outputs stay stable, handshakes pop and compare.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge aclk);
      #1;
      if (!aresetn) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        check("hold_data", m_tdata, held_d);
        check("hold_last", 32'(m_tlast), 32'(held_l));
      end
      check("out_valid", 32'(m_tvalid), 32'(exp_q.size() != 0));
      if (m_tvalid && !m_tready) check("stall_s_tready", 32'(s_tready), 32'd0);
      if (m_tvalid && m_tready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("result_data", m_tdata, e[32:1]);
        check("result_last", 32'(m_tlast), 32'(e[0]));
      end
      held   = m_tvalid && !m_tready;
      held_d = m_tdata;
      held_l = m_tlast;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    logic v, l, mr;
    logic [31:0] d;

    // Reset state
    #12;
    check("reset_valid", 32'(m_tvalid), 32'd0);
    check("reset_data", m_tdata, 32'd0);
    check("reset_last", 32'(m_tlast), 32'd0);
    check("reset_s_tready", 32'(s_tready), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    m_tready = 1'b1;

    // Dot-product style group on consecutive cycles
    send(32'h42D00000, 1'b0, 1'b1, 32'h42D00000);
    send(32'h42560000, 1'b0, 1'b1, 32'h431D8000);
    send(32'h424C0000, 1'b1, 1'b1, 32'h43508000);

    // Subnormal chain up to the normal boundary
    for (int k = 0; k < 23; k++) send(32'd1 << k, 1'b0, 1'b1, (32'd1 << (k + 1)) - 32'd1);
    send(32'h00800000, 1'b1, 1'b1, 32'h00FFFFFF);

    // Specials
    send(32'h7F800000, 1'b0, 1'b1, 32'h7F800000);
    send(32'hFF800000, 1'b1, 1'b1, 32'h7FC00000);
    send(32'h7F7FFFFF, 1'b0, 1'b1, 32'h7F7FFFFF);
    send(32'h7F7FFFFF, 1'b1, 1'b1, 32'h7F800000);
    send(32'h3F800000, 1'b0, 1'b1, 32'h3F800000);
    send(32'hBF800000, 1'b1, 1'b1, 32'h00000000);
    send(32'h7FA00001, 1'b1, 1'b1, 32'h7FC00000);
    send(32'h80000000, 1'b0, 1'b1, 32'h80000000);
    send(32'h80000000, 1'b1, 1'b1, 32'h80000000);

    // Group boundary: no carry-over
    send(32'h3F800000, 1'b1, 1'b1, 32'h3F800000);
    send(32'h40000000, 1'b1, 1'b1, 32'h40000000);

    // Backpressure mid-group
    send(32'h3F800000, 1'b0, 1'b1, 32'h3F800000);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 32'h3F800000, 1'b0, 1'b0, a);
      check("bp_s_tready", 32'(s_tready), 32'd0);
      if (a) record(32'h3F800000, 1'b0, 1'b0, 32'd0);
    end
    send(32'h3F800000, 1'b0, 1'b1, 32'h40000000);
    send(32'h3F800000, 1'b1, 1'b1, 32'h40400000);
    idle(2);

    // Reset mid-group discards the partial sum
    send(32'h3F800000, 1'b0, 1'b1, 32'h3F800000);
    @(negedge aclk);
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    exp_q.delete();
    m_first = 1'b1;
    m_acc   = 32'd0;
    #2;
    check("midrst_valid", 32'(m_tvalid), 32'd0);
    check("midrst_data", m_tdata, 32'd0);
    check("midrst_last", 32'(m_tlast), 32'd0);
    check("midrst_s_tready", 32'(s_tready), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    send(32'h40400000, 1'b1, 1'b1, 32'h40400000);
    idle(2);

    // Randomized traffic against the exact-arithmetic model
    for (int i = 0; i < 3000; i++) begin
      v  = ($urandom_range(0, 9) < 7);
      mr = ($urandom_range(0, 9) < 7);
      l  = ($urandom_range(0, 3) == 0);
      d  = gen_operand(m_acc);
      cycle(v, d, l, mr, a);
      if (a) record(d, l, 1'b0, 32'd0);
    end
    idle(6);

    check("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_acc.md
# fp_acc

- Streaming IEEE-754 single-precision accumulator with AXI4-Stream input and output.
- Sums consecutive input beats into a running total and emits one running-sum beat per accepted input.
- `tlast` on an input closes the current group; the output beat for that input carries `tlast` and holds the group total.
- Sits in the matrix/vector datapath, reducing products into dot-product results.

## Interface

No parameters. Data format is fixed: 32-bit IEEE-754 binary32.

One clock; reset is asynchronous and active-low.

- aclk  in  1  clock; all state updates on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_a_tdata  in  32  operand (binary32).
- s_axis_a_tvalid  in  1  operand valid.
- s_axis_a_tlast  in  1  operand is the last of its group.
- s_axis_a_tready  out  1  block can accept an operand.
- m_axis_result_tdata  out  32  running sum (binary32).
- m_axis_result_tvalid  out  1  result valid.
- m_axis_result_tready  in  1  downstream accepts the result.
- m_axis_result_tlast  out  1  result is a group total.

## Operation

State:
- acc[31:0]: running sum.
- first: 1 when the next accepted beat starts a new group.

Acceptance and readiness:
- A beat is accepted when s_axis_a_tvalid && s_axis_a_tready at a rising edge.
- s_axis_a_tready = aresetn && (!m_axis_result_tvalid || m_axis_result_tready). This is combinational; no skid buffer.

On an accepted beat with operand a:
- sum = a if first, otherwise acc + a.
- m_axis_result_tdata <= sum.
- m_axis_result_tlast <= s_axis_a_tlast.
- m_axis_result_tvalid <= 1.
- If s_axis_a_tlast: first <= 1, acc don't-care.
- Otherwise: first <= 0, acc <= sum.

If no beat is accepted and m_axis_result_tready is 1, m_axis_result_tvalid <= 0.

Addition rules (round-to-nearest-even):
- Full gradual underflow. Subnormal inputs and results are exact per IEEE; no flush-to-zero.
- Overflow returns ±inf (0x7F800000 / 0xFF800000).
- Any NaN operand, or +inf + -inf, returns canonical quiet NaN 0x7FC00000.
- On the first beat of a group, a NaN operand is also replaced with 0x7FC00000. All other first-beat operands, including -0, pass through bit-exact.
- Exact zero sum: -0 only if both operands are -0; otherwise +0.
- inf + finite returns that inf.

Implementation notes:
- The adder path is single-cycle combinational: unpack, align with guard/round/sticky, add/subtract, normalize, round, repack.
- No internal pipelining, so acc feedback supports back-to-back beats.

## Timing

- Latency: 1 cycle. The result for a beat accepted at edge N is valid after edge N and holds until taken.
- Throughput: 1 beat per cycle while m_axis_result_tready = 1.
- Backpressure: with m_axis_result_tvalid = 1 and m_axis_result_tready = 0, m_axis_result_tdata, m_axis_result_tlast and m_axis_result_tvalid stay stable, and s_axis_a_tready = 0.
- Input data with s_axis_a_tvalid = 0 is ignored, including its tdata and tlast.
- Reset (asynchronous assert, synchronous-safe deassert): m_axis_result_tvalid = 0, m_axis_result_tdata = 0, m_axis_result_tlast = 0, acc = 0, first = 1, s_axis_a_tready = 0.
- Reset mid-group discards the partial sum; the first beat after reset starts a new group.
- A single-beat group (tlast on its first beat) outputs the operand itself with tlast = 1.
- A tlast beat followed immediately by another beat starts a new sum with no bubble.

## Test plan

- Group 0x42D00000 (104), 0x42560000 (53.5), 0x424C0000 (51, tlast) sent on consecutive cycles:
  - Results 0x42D00000, 0x431D8000, 0x43508000 with tlast = 0, 0, 1, each one cycle after its input.
- Subnormal chain 0x00000001, 0x00000002, 0x00000004 … 0x00400000, then 0x00800000:
  - Running sums 0x00000001, 0x00000003, 0x00000007 … 0x007FFFFF, then 0x00FFFFFF.
- Specials:
  - 0x7F800000 then 0xFF800000 (tlast) -> 0x7F800000, 0x7FC00000.
  - 0x7F7FFFFF then 0x7F7FFFFF (tlast) -> second result 0x7F800000.
  - 0x3F800000 then 0xBF800000 (tlast) -> second result 0x00000000.
- Group reset: 0x3F800000 (tlast), then 0x40000000 (tlast):
  - Results 0x3F800000, 0x40000000 (no carry-over between groups).
- Backpressure: hold m_axis_result_tready = 0 for 3 cycles mid-group.
  - s_axis_a_tready = 0 throughout and the output is stable.
  - After release, no beat is lost or duplicated.
  - Sums match the unstalled run.
- Reset: assert aresetn = 0 mid-group.
  - Outputs go to 0 immediately.
  - After release, 0x40400000 (tlast) -> 0x40400000.
